// File: rtl/sap2_controller_sequencer_if.sv
// Bus bundle for the SAP-2 controller/sequencer: mode/step inputs, opcode and flags in,
// control word, T-state, halt and retire count out.
interface sap2_controller_sequencer_if #(
    parameter int unsigned OPC_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic             auto_sw;
    logic             step;
    logic [OPC_W-1:0] instr;
    logic             zero_flag;
    logic             neg_flag;

    logic             Cp;
    logic             Ep;
    logic             Ea;
    logic             Su;
    logic             Eu;
    logic             Lp;
    logic             Lm_bar;
    logic             CE_bar;
    logic             Li_bar;
    logic             Ei_bar;
    logic             La_bar;
    logic             Lb_bar;
    logic             Lo_bar;
    logic             We_bar;

    logic [5:0]       t_state;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        output auto_sw, step, instr, zero_flag, neg_flag,
        input  Cp, Ep, Ea, Su, Eu, Lp,
        input  Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar, We_bar,
        input  t_state, halted, retired
    );

    modport slave (
        input  auto_sw, step, instr, zero_flag, neg_flag,
        output Cp, Ep, Ea, Su, Eu, Lp,
        output Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar, We_bar,
        output t_state, halted, retired
    );
endinterface

// File: rtl/sap2_controller_sequencer.sv
// SAP-2 style ring-counter controller: one-hot T1..T6 sequencer, opcode decode into the
// control word, halt latch and retired-instruction counter.
module sap2_controller_sequencer #(
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned EARLY_END = 1,
    parameter int unsigned CNT_W     = 16
) (
    input logic                      CLK,
    input logic                      CLR,
    sap2_controller_sequencer_if.slave bus
);

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } tstate_e;

    localparam logic [3:0] OpLda = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpJmp = 4'h3;
    localparam logic [3:0] OpJz  = 4'h4;
    localparam logic [3:0] OpJn  = 4'h5;
    localparam logic [3:0] OpLdi = 4'h6;
    localparam logic [3:0] OpSta = 4'h7;
    localparam logic [3:0] OpNop = 4'hD;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    tstate_e          t_q, t_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [OPC_W-1:0] instr_w;
    logic [3:0]       op;
    logic             adv;
    tstate_e          last_t;

    logic cp, ep, ea, su, eu, lp;
    logic lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, we_n;

    assign instr_w = bus.instr;
    assign adv     = !CLR && !halted_q && (bus.auto_sw || bus.step);

    // Any set bit above the low nibble makes the opcode unknown; treat it as a NOP.
    always_comb begin
        op = instr_w[3:0];
        if ((instr_w >> 4) != '0) begin
            op = OpNop;
        end
    end

    always_comb begin
        last_t = StT4;
        if (EARLY_END == 0) begin
            last_t = StT6;
        end else begin
            case (op)
                OpLda, OpSta: last_t = StT5;
                OpAdd, OpSub: last_t = StT6;
                default:      last_t = StT4;
            endcase
        end
    end

    always_comb begin
        t_d       = t_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (CLR) begin
            t_d       = StT1;
            halted_d  = 1'b0;
            retired_d = '0;
        end else if (adv) begin
            if (t_q == last_t) begin
                t_d       = StT1;
                retired_d = retired_q + CNT_W'(1);
                if (op == OpHlt) begin
                    halted_d = 1'b1;
                end
            end else begin
                unique case (t_q)
                    StT1:    t_d = StT2;
                    StT2:    t_d = StT3;
                    StT3:    t_d = StT4;
                    StT4:    t_d = StT5;
                    StT5:    t_d = StT6;
                    default: t_d = StT1;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        t_q       <= t_d;
        halted_q  <= halted_d;
        retired_q <= retired_d;
    end

    // Level enables follow the T-state; load/write strobes fire only on advancing clocks.
    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        lp   = 1'b0;
        lm_n = 1'b1;
        ce_n = 1'b1;
        li_n = 1'b1;
        ei_n = 1'b1;
        la_n = 1'b1;
        lb_n = 1'b1;
        lo_n = 1'b1;
        we_n = 1'b1;
        if (!CLR && !halted_q) begin
            unique case (t_q)
                StT1: begin
                    ep   = 1'b1;
                    lm_n = !adv;
                end
                StT2: begin
                    cp = adv;
                end
                StT3: begin
                    ce_n = 1'b0;
                    li_n = !adv;
                end
                StT4: begin
                    case (op)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            ei_n = 1'b0;
                            lm_n = !adv;
                        end
                        OpJmp: begin
                            ei_n = 1'b0;
                            lp   = adv;
                        end
                        OpJz: begin
                            ei_n = 1'b0;
                            lp   = adv && bus.zero_flag;
                        end
                        OpJn: begin
                            ei_n = 1'b0;
                            lp   = adv && bus.neg_flag;
                        end
                        OpLdi: begin
                            ei_n = 1'b0;
                            la_n = !adv;
                        end
                        OpOut: begin
                            ea   = 1'b1;
                            lo_n = !adv;
                        end
                        default: ;
                    endcase
                end
                StT5: begin
                    case (op)
                        OpLda: begin
                            ce_n = 1'b0;
                            la_n = !adv;
                        end
                        OpAdd, OpSub: begin
                            ce_n = 1'b0;
                            lb_n = !adv;
                        end
                        OpSta: begin
                            ea   = 1'b1;
                            we_n = !adv;
                        end
                        default: ;
                    endcase
                end
                StT6: begin
                    case (op)
                        OpAdd: begin
                            eu   = 1'b1;
                            la_n = !adv;
                        end
                        OpSub: begin
                            eu   = 1'b1;
                            su   = 1'b1;
                            la_n = !adv;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.Cp      = cp;
    assign bus.Ep      = ep;
    assign bus.Ea      = ea;
    assign bus.Su      = su;
    assign bus.Eu      = eu;
    assign bus.Lp      = lp;
    assign bus.Lm_bar  = lm_n;
    assign bus.CE_bar  = ce_n;
    assign bus.Li_bar  = li_n;
    assign bus.Ei_bar  = ei_n;
    assign bus.La_bar  = la_n;
    assign bus.Lb_bar  = lb_n;
    assign bus.Lo_bar  = lo_n;
    assign bus.We_bar  = we_n;
    assign bus.t_state = t_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_sap2_controller_sequencer.sv
// Directed bench: three controller instances (early-end, SAP-1 timing, 2-bit counter)
// checked with immediate assertions against hand-computed control words.
module tb_sap2_controller_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic clr0, clr1, clr2;

    sap2_controller_sequencer_if #(.OPC_W(4), .CNT_W(16)) if0 ();
    sap2_controller_sequencer_if #(.OPC_W(4), .CNT_W(16)) if1 ();
    sap2_controller_sequencer_if #(.OPC_W(4), .CNT_W(2))  if2 ();

    sap2_controller_sequencer #(.OPC_W(4), .EARLY_END(1), .CNT_W(16)) u0 (
        .CLK(CLK), .CLR(clr0), .bus(if0.slave)
    );
    sap2_controller_sequencer #(.OPC_W(4), .EARLY_END(0), .CNT_W(16)) u1 (
        .CLK(CLK), .CLR(clr1), .bus(if1.slave)
    );
    sap2_controller_sequencer #(.OPC_W(4), .EARLY_END(1), .CNT_W(2)) u2 (
        .CLK(CLK), .CLR(clr2), .bus(if2.slave)
    );

    // Control word order: Cp Ep Ea Su Eu Lp | Lm CE Li Ei La Lb Lo We (last eight active-low)
    wire [13:0] ctl0 = {if0.Cp, if0.Ep, if0.Ea, if0.Su, if0.Eu, if0.Lp, if0.Lm_bar, if0.CE_bar,
                        if0.Li_bar, if0.Ei_bar, if0.La_bar, if0.Lb_bar, if0.Lo_bar, if0.We_bar};
    wire [13:0] ctl1 = {if1.Cp, if1.Ep, if1.Ea, if1.Su, if1.Eu, if1.Lp, if1.Lm_bar, if1.CE_bar,
                        if1.Li_bar, if1.Ei_bar, if1.La_bar, if1.Lb_bar, if1.Lo_bar, if1.We_bar};
    wire [13:0] ctl2 = {if2.Cp, if2.Ep, if2.Ea, if2.Su, if2.Eu, if2.Lp, if2.Lm_bar, if2.CE_bar,
                        if2.Li_bar, if2.Ei_bar, if2.La_bar, if2.Lb_bar, if2.Lo_bar, if2.We_bar};

    localparam logic [13:0] CP = 14'h2000, EP = 14'h1000, EA = 14'h0800, SU = 14'h0400;
    localparam logic [13:0] EU = 14'h0200, LP = 14'h0100, LM = 14'h0080, CE = 14'h0040;
    localparam logic [13:0] LI = 14'h0020, EI = 14'h0010, LA = 14'h0008, LB = 14'h0004;
    localparam logic [13:0] LO = 14'h0002, WE = 14'h0001;
    localparam logic [13:0] INACT = 14'h00FF;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance 0: check T-state and control word mid-cycle, then advance.
    task automatic cyc0(input string tag, input logic [5:0] exp_t, input logic [13:0] act);
        @(negedge CLK);
        chk({tag, "_t"}, {26'd0, if0.t_state}, {26'd0, exp_t});
        chk({tag, "_ctl"}, {18'd0, ctl0}, {18'd0, INACT ^ act});
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch0(input string tag);
        cyc0({tag, "_f1"}, 6'd1, EP | LM);
        cyc0({tag, "_f2"}, 6'd2, CP);
        cyc0({tag, "_f3"}, 6'd4, CE | LI);
    endtask

    logic [3:0] prog [4];
    logic [1:0] nop_ret [5];
    logic [13:0] lvl_ctl [3];
    logic [13:0] stb_ctl [3];

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        prog = '{4'h0, 4'h1, 4'hE, 4'hF};
        nop_ret = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        lvl_ctl = '{EP, 14'h0000, CE};
        stb_ctl = '{EP | LM, CP, CE | LI};

        clr0 = 1'b1;
        clr1 = 1'b1;
        clr2 = 1'b1;
        if0.auto_sw = 1'b1; if0.step = 1'b0; if0.instr = 4'h0;
        if0.zero_flag = 1'b0; if0.neg_flag = 1'b0;
        if1.auto_sw = 1'b1; if1.step = 1'b0; if1.instr = 4'h0;
        if1.zero_flag = 1'b0; if1.neg_flag = 1'b0;
        if2.auto_sw = 1'b1; if2.step = 1'b0; if2.instr = 4'hA;
        if2.zero_flag = 1'b0; if2.neg_flag = 1'b0;

        @(posedge CLK); #1;
        @(posedge CLK); #1;

        // Reset state while CLR is held with auto_sw high
        @(negedge CLK);
        chk("rst_t", {26'd0, if0.t_state}, 32'd1);
        chk("rst_halted", {31'd0, if0.halted}, 32'd0);
        chk("rst_retired", {16'd0, if0.retired}, 32'd0);
        chk("rst_ctl", {18'd0, ctl0}, {18'd0, INACT});
        @(posedge CLK); #1;

        // LDA, ADD, OUT, HLT with early end: 5 + 6 + 4 + 4 clocks
        clr0 = 1'b0;
        if0.instr = 4'h0;
        fetch0("lda");
        cyc0("lda_t4", 6'd8, EI | LM);
        cyc0("lda_t5", 6'd16, CE | LA);
        chk("lda_ret", {16'd0, if0.retired}, 32'd1);
        if0.instr = 4'h1;
        fetch0("add");
        cyc0("add_t4", 6'd8, EI | LM);
        cyc0("add_t5", 6'd16, CE | LB);
        cyc0("add_t6", 6'd32, EU | LA);
        chk("add_ret", {16'd0, if0.retired}, 32'd2);
        if0.instr = 4'hE;
        fetch0("out");
        cyc0("out_t4", 6'd8, EA | LO);
        if0.instr = 4'hF;
        fetch0("hlt");
        cyc0("hlt_t4", 6'd8, 14'h0000);
        chk("hlt_halted", {31'd0, if0.halted}, 32'd1);
        chk("hlt_ret", {16'd0, if0.retired}, 32'd4);
        if0.step = 1'b1;
        cyc0("halt_hold1", 6'd1, 14'h0000);
        cyc0("halt_hold2", 6'd1, 14'h0000);
        chk("halt_hold_ret", {16'd0, if0.retired}, 32'd4);
        if0.step = 1'b0;

        // Same program, SAP-1 timing: 6 clocks per instruction, halted after 24
        clr1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if1.instr = prog[i];
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                chk("sap1_t", {26'd0, if1.t_state}, 32'd1 << k);
                chk("sap1_not_halted", {31'd0, if1.halted}, 32'd0);
                if (i == 0 && k == 5) chk("sap1_lda_t6", {18'd0, ctl1}, {18'd0, INACT});
                if (i == 3 && k == 3) chk("sap1_hlt_t4", {18'd0, ctl1}, {18'd0, INACT});
                @(posedge CLK); #1;
            end
        end
        chk("sap1_halted", {31'd0, if1.halted}, 32'd1);
        chk("sap1_ret", {16'd0, if1.retired}, 32'd4);
        chk("sap1_t_end", {26'd0, if1.t_state}, 32'd1);

        // CLR clears halted
        clr0 = 1'b1;
        @(negedge CLK);
        chk("clr_halt_ctl", {18'd0, ctl0}, {18'd0, INACT});
        @(posedge CLK); #1;
        clr0 = 1'b0;
        chk("clr_halted", {31'd0, if0.halted}, 32'd0);
        chk("clr_ret", {16'd0, if0.retired}, 32'd0);
        chk("clr_t", {26'd0, if0.t_state}, 32'd1);

        // Conditional jumps
        if0.instr = 4'h4;
        if0.zero_flag = 1'b0;
        fetch0("jz0");
        cyc0("jz0_t4", 6'd8, EI);
        if0.zero_flag = 1'b1;
        fetch0("jz1");
        cyc0("jz1_t4", 6'd8, EI | LP);
        if0.zero_flag = 1'b0;
        if0.instr = 4'h5;
        if0.neg_flag = 1'b1;
        fetch0("jn1");
        cyc0("jn1_t4", 6'd8, EI | LP);
        if0.neg_flag = 1'b0;
        fetch0("jn0");
        cyc0("jn0_t4", 6'd8, EI);
        chk("jmp_ret", {16'd0, if0.retired}, 32'd4);

        // Manual stepping through fetch, one pulse every 5 clocks
        if0.auto_sw = 1'b0;
        if0.instr = 4'h6;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                cyc0("man_idle", 6'd1 << p, lvl_ctl[p]);
            end
            if0.step = 1'b1;
            cyc0("man_step", 6'd1 << p, stb_ctl[p]);
            if0.step = 1'b0;
        end
        cyc0("man_t4_idle", 6'd8, EI);
        if0.step = 1'b1;
        cyc0("man_long1", 6'd8, EI | LA);
        cyc0("man_long2", 6'd1, EP | LM);
        if0.step = 1'b0;
        cyc0("man_after", 6'd2, 14'h0000);
        chk("man_ret", {16'd0, if0.retired}, 32'd5);

        // CLR during T5 of ADD aborts the instruction
        if0.auto_sw = 1'b1;
        clr0 = 1'b1;
        cyc0("clr_mid", 6'd2, 14'h0000);
        clr0 = 1'b0;
        if0.instr = 4'h1;
        fetch0("add2");
        cyc0("add2_t4", 6'd8, EI | LM);
        clr0 = 1'b1;
        cyc0("add2_t5_clr", 6'd16, 14'h0000);
        clr0 = 1'b0;
        chk("add2_clr_ret", {16'd0, if0.retired}, 32'd0);
        cyc0("add2_after", 6'd1, EP | LM);

        // Narrow counter wraps over five NOPs
        clr2 = 1'b0;
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                chk("nop_t", {26'd0, if2.t_state}, 32'd1 << k);
                if (k == 3) chk("nop_t4_ctl", {18'd0, ctl2}, {18'd0, INACT});
                @(posedge CLK); #1;
            end
            chk("nop_ret", {30'd0, if2.retired}, {30'd0, nop_ret[n]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap2_controller_sequencer.md
SAP2_CONTROLLER_SEQUENCER -- requirements
Module: sap2_controller_sequencer

Interface
REQ-001 SHALL have parameter OPC_W, default 4: opcode width; opcodes decode on the low 4 bits, and any upper bits must be zero or the opcode is unknown.
REQ-002 SHALL have parameter EARLY_END, default 1: 1 = instruction ends after its last active T-state; 0 = every instruction runs T1..T6 (SAP-1 timing).
REQ-003 SHALL have parameter CNT_W, default 16: width of retired-instruction counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset: CLK is the single clock, all state updates on its rising edge; CLR is the synchronous, active-high reset.
REQ-005 Ports, in order:
  CLK  in  1  clock
  CLR  in  1  synchronous reset, active-high
  auto_sw  in  1  1 = advance every clock; 0 = manual
  step  in  1  debounced single-cycle pulse; advances one T-state in manual mode
  instr  in  OPC_W  opcode from instruction register
  zero_flag  in  1  accumulator == 0
  neg_flag  in  1  accumulator MSB
  Cp, Ep, Ea, Su, Eu, Lp  out  1  active-high controls (Lp = PC parallel load)
  Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Lb_bar, Lo_bar, We_bar  out  1  active-low controls (We_bar = RAM write)
  t_state  out  6  one-hot current T-state, bit0 = T1
  halted  out  1  HLT executed
  retired  out  CNT_W  instructions completed

Function
REQ-006 adv = !CLR && !halted && (auto_sw || step); t_state moves only on clocks where adv = 1.
REQ-007 Level controls (Ep, CE_bar, Ei_bar, Ea, Eu, Su) SHALL follow current T-state whenever not halted and not in reset; strobes (Cp, Lm_bar, Li_bar, La_bar, Lb_bar, Lo_bar, Lp, We_bar) SHALL assert only in cycles with adv = 1.
REQ-008 Fetch: T1 Ep, Lm_bar; T2 Cp; T3 CE_bar, Li_bar; identical for all opcodes.
REQ-009 Execute (T4 / T5 / T6; "end" = last state when EARLY_END = 1):
  0 LDA: Ei_bar, Lm_bar / CE_bar, La_bar / -- ; end T5
  1 ADD: Ei_bar, Lm_bar / CE_bar, Lb_bar / Eu, La_bar ; end T6
  2 SUB: as ADD plus Su in T6 ; end T6
  3 JMP: Ei_bar, Lp ; end T4
  4 JZ: Ei_bar, Lp only if zero_flag = 1 sampled in T4 ; end T4
  5 JN: as JZ using neg_flag ; end T4
  6 LDI: Ei_bar, La_bar ; end T4
  7 STA: Ei_bar, Lm_bar / Ea, We_bar ; end T5
  E OUT: Ea, Lo_bar ; end T4
  F HLT: set halted at end of T4 ; no other control
  others: NOP, no control asserted ; end T4
REQ-010 On adv in end state: t_state -> T1 and retired increments (wraps 2^CNT_W-1 -> 0); EARLY_END = 0 forces end state T6 for all opcodes.
REQ-011 instr SHALL be sampled in each execute state; decode is undefined if instr changes during T4-T6.
REQ-012 HLT: on the adv clock in T4, halted <= 1, retired increments, t_state <= T1; while halted, all controls inactive and step/auto_sw are ignored.
REQ-013 step is ignored when auto_sw = 1; a step pulse lasting >1 clock advances once per clock it is high.

Reset
REQ-014 While CLR = 1 at a clock: t_state <= 6'b000001, halted <= 0, retired <= 0; all controls inactive (active-high 0, active-low 1) during cycles with CLR = 1.
REQ-015 CLR SHALL take priority over adv and halted, aborting any instruction mid-T-state; the first cycle after release is T1 of a new fetch.

Verification
REQ-016 auto_sw = 1, EARLY_END = 1, program LDA, ADD, OUT, HLT -> T-state counts 5, 6, 4, 4; retired = 4 and halted = 1 after 19 clocks from reset release.
REQ-017 Same program, EARLY_END = 0 -> every instruction spans 6 clocks; halted after 24 clocks; retired = 4.
REQ-018 JZ with zero_flag = 0 then zero_flag = 1 -> Lp low in the first case, high for exactly one cycle in T4 of the second case.
REQ-019 auto_sw = 0, step pulsed 3 times 5 clocks apart -> t_state walks T1 -> T4; Cp asserted only in the single clock where step is high during T2.
REQ-020 CLR asserted during T5 of ADD -> next cycle t_state = T1, retired = 0, no La_bar strobe; after halt, CLR clears halted.
REQ-021 CNT_W = 2, 5 NOPs -> retired reads 1, 2, 3, 0, 1.
